// File: rtl/k052109_video_timing.sv
// Master timing generator for the k052109 tilemap core.
// Divides CK into 12/6/3 MHz phases, runs the pixel and line counters, and registers the blank, sync and vblank IRQ decodes.
module k052109_video_timing #(
    parameter int H_TOTAL     = 384,
    parameter int V_TOTAL     = 264,
    parameter int H_ACTIVE    = 320,
    parameter int HS_START    = 336,
    parameter int HS_END      = 368,
    parameter int V_ACT_START = 16,
    parameter int V_ACT_END   = 240,
    parameter int VS_START    = 248,
    parameter int VS_END      = 256
) (
    input  logic       CK,
    input  logic       Rn,
    input  logic       irq_en,
    input  logic       irq_ack,
    output logic       clk12,
    output logic       clk6,
    output logic       clk3,
    output logic       pix_en,
    output logic [8:0] hcnt,
    output logic [8:0] vcnt,
    output logic       hblank_n,
    output logic       vblank_n,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       csync_n,
    output logic       irq_n
);

    localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_ACT   = 9'(H_ACTIVE);
    localparam logic [8:0] HS_BEG  = 9'(HS_START);
    localparam logic [8:0] HS_FIN  = 9'(HS_END);
    localparam logic [8:0] VA_BEG  = 9'(V_ACT_START);
    localparam logic [8:0] VA_FIN  = 9'(V_ACT_END);
    localparam logic [8:0] VS_BEG  = 9'(VS_START);
    localparam logic [8:0] VS_FIN  = 9'(VS_END);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } irq_state_t;

    logic [2:0] div_reg;
    logic [2:0] div_next;
    logic       clk12_reg;
    logic       clk6_reg;
    logic       clk3_reg;
    logic       pix_en_reg;
    logic [8:0] hcnt_reg;
    logic [8:0] hcnt_next;
    logic [8:0] vcnt_reg;
    logic [8:0] vcnt_next;
    logic       line_end;
    logic       vblank_start;
    logic       hblank_n_reg;
    logic       vblank_n_reg;
    logic       hsync_n_reg;
    logic       vsync_n_reg;
    logic       csync_n_reg;
    logic       hsync_n_next;
    logic       vsync_n_next;
    irq_state_t irq_state_reg;
    logic       irq_n_reg;

    // pix_en_reg marks the CK edge on which clk6 rises; the counters step on that edge.
    always_comb begin
        div_next     = div_reg + 3'd1;
        line_end     = pix_en_reg && (hcnt_reg == H_LAST);
        hcnt_next    = hcnt_reg;
        vcnt_next    = vcnt_reg;
        if (pix_en_reg) begin
            hcnt_next = line_end ? 9'd0 : hcnt_reg + 9'd1;
        end
        if (line_end) begin
            vcnt_next = (vcnt_reg == V_LAST) ? 9'd0 : vcnt_reg + 9'd1;
        end
        vblank_start = line_end && (vcnt_next == VA_FIN);
        hsync_n_next = !((hcnt_next >= HS_BEG) && (hcnt_next < HS_FIN));
        vsync_n_next = !((vcnt_next >= VS_BEG) && (vcnt_next < VS_FIN));
    end

    always_ff @(posedge CK or negedge Rn) begin
        if (!Rn) begin
            div_reg      <= 3'd0;
            clk12_reg    <= 1'b0;
            clk6_reg     <= 1'b0;
            clk3_reg     <= 1'b0;
            pix_en_reg   <= 1'b0;
            hcnt_reg     <= 9'd0;
            vcnt_reg     <= 9'd0;
            hblank_n_reg <= 1'b1;
            vblank_n_reg <= 1'b0;
            hsync_n_reg  <= 1'b1;
            vsync_n_reg  <= 1'b1;
            csync_n_reg  <= 1'b1;
        end else begin
            div_reg      <= div_next;
            clk12_reg    <= div_next[0];
            clk6_reg     <= div_next[1];
            clk3_reg     <= div_next[2];
            pix_en_reg   <= (div_next[1:0] == 2'b01);
            hcnt_reg     <= hcnt_next;
            vcnt_reg     <= vcnt_next;
            // Decodes use next-state counts so they align with the counter edge.
            hblank_n_reg <= (hcnt_next < H_ACT);
            vblank_n_reg <= (vcnt_next >= VA_BEG) && (vcnt_next < VA_FIN);
            hsync_n_reg  <= hsync_n_next;
            vsync_n_reg  <= vsync_n_next;
            csync_n_reg  <= hsync_n_next & vsync_n_next;
        end
    end

    // Ack (or enable dropping) always beats a simultaneous vblank set.
    always_ff @(posedge CK or negedge Rn) begin
        if (!Rn) begin
            irq_state_reg <= IDLE;
            irq_n_reg     <= 1'b1;
        end else begin
            case (irq_state_reg)
                IDLE: begin
                    if (vblank_start && irq_en && !irq_ack) begin
                        irq_state_reg <= PENDING;
                        irq_n_reg     <= 1'b0;
                    end
                end
                PENDING: begin
                    if (irq_ack || !irq_en) begin
                        irq_state_reg <= IDLE;
                        irq_n_reg     <= 1'b1;
                    end
                end
                default: begin
                    irq_state_reg <= IDLE;
                    irq_n_reg     <= 1'b1;
                end
            endcase
        end
    end

    assign clk12    = clk12_reg;
    assign clk6     = clk6_reg;
    assign clk3     = clk3_reg;
    assign pix_en   = pix_en_reg;
    assign hcnt     = hcnt_reg;
    assign vcnt     = vcnt_reg;
    assign hblank_n = hblank_n_reg;
    assign vblank_n = vblank_n_reg;
    assign hsync_n  = hsync_n_reg;
    assign vsync_n  = vsync_n_reg;
    assign csync_n  = csync_n_reg;
    assign irq_n    = irq_n_reg;

endmodule

// File: tb/tb_k052109_video_timing.sv
// Bench for k052109_video_timing: closed-form timing model feeds a scoreboard queue, plus directed checks.
// Uses shrunken line/frame sizes so several frames fit in a short run.
module tb_k052109_video_timing;

    localparam int H_TOTAL     = 48;
    localparam int V_TOTAL     = 24;
    localparam int H_ACTIVE    = 40;
    localparam int HS_START    = 42;
    localparam int HS_END      = 46;
    localparam int V_ACT_START = 2;
    localparam int V_ACT_END   = 20;
    localparam int VS_START    = 21;
    localparam int VS_END      = 23;
    localparam int BUDGET      = 12000;
    localparam logic [27:0] RST_VEC = {4'b0000, 9'd0, 9'd0, 6'b101111};

    logic       CK = 1'b0;
    logic       Rn = 1'b1;
    logic       irq_en = 1'b0;
    logic       irq_ack = 1'b0;
    logic       clk12, clk6, clk3, pix_en;
    logic [8:0] hcnt, vcnt;
    logic       hblank_n, vblank_n, hsync_n, vsync_n, csync_n, irq_n;
    logic [27:0] outs;

    int total = 0;
    int bad = 0;
    int n = 0;
    bit irq_p = 1'b0;
    logic [27:0] exp_q[$];

    k052109_video_timing #(
        .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_ACTIVE(H_ACTIVE),
        .HS_START(HS_START), .HS_END(HS_END),
        .V_ACT_START(V_ACT_START), .V_ACT_END(V_ACT_END),
        .VS_START(VS_START), .VS_END(VS_END)
    ) dut (
        .CK(CK), .Rn(Rn), .irq_en(irq_en), .irq_ack(irq_ack),
        .clk12(clk12), .clk6(clk6), .clk3(clk3), .pix_en(pix_en),
        .hcnt(hcnt), .vcnt(vcnt),
        .hblank_n(hblank_n), .vblank_n(vblank_n),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .csync_n(csync_n),
        .irq_n(irq_n)
    );

    always #5 CK = ~CK;

    assign outs = {clk12, clk6, clk3, pix_en, hcnt, vcnt,
                   hblank_n, vblank_n, hsync_n, vsync_n, csync_n, irq_n};

    task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Expected outputs after n edges since release: pixel steps happen at edges 2, 6, 10, ...
    function automatic logic [27:0] expect_vec(input int edges, input bit pend);
        int a, h, v, d;
        logic [2:0] db;
        logic hb, vb, hs, vs;
        a  = (edges + 2) / 4;
        h  = a % H_TOTAL;
        v  = (a / H_TOTAL) % V_TOTAL;
        d  = edges % 8;
        db = 3'(d);
        hb = (h < H_ACTIVE);
        vb = (v >= V_ACT_START) && (v < V_ACT_END);
        hs = !((h >= HS_START) && (h < HS_END));
        vs = !((v >= VS_START) && (v < VS_END));
        return {db[0], db[1], db[2], (edges % 4 == 1), 9'(h), 9'(v),
                hb, vb, hs, vs, hs & vs, !pend};
    endfunction

    // Model: advances on each edge and pushes the expectation for that edge.
    always @(posedge CK) begin
        int a_new, a_old;
        if (!Rn) begin
            n = 0;
            irq_p = 1'b0;
        end else begin
            n++;
            a_new = (n + 2) / 4;
            a_old = (n + 1) / 4;
            if (irq_p) begin
                if (irq_ack || !irq_en) irq_p = 1'b0;
            end else if (a_new != a_old && (a_new % H_TOTAL) == 0 &&
                         ((a_new / H_TOTAL) % V_TOTAL) == V_ACT_END &&
                         irq_en && !irq_ack) begin
                irq_p = 1'b1;
            end
        end
        exp_q.push_back(expect_vec(n, irq_p));
    end

    always @(negedge CK) begin
        logic [27:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle", outs, e);
        end
    end

    // Returns on a negedge where hcnt/vcnt match (and pix_en is high if need_pix).
    task automatic wait_hv(input int h, input int v, input bit need_pix);
        int k = 0;
        while (!(hcnt == 9'(h) && vcnt == 9'(v) && (!need_pix || pix_en)) && k < BUDGET) begin
            @(negedge CK);
            k++;
        end
        chk("wait_bound", 28'(k < BUDGET), 28'd1);
    endtask

    initial begin
        int cnt_hs, cnt_hb;
        #1 Rn = 1'b0;
        repeat (3) @(posedge CK);
        @(negedge CK);
        #1 chk("reset_state", outs, RST_VEC);
        #1 Rn = 1'b1;

        // First edge after release raises pix_en; clk6 rises on the following edge.
        @(negedge CK);
        chk("pix_en_first", 28'(pix_en), 28'd1);
        chk("clk6_pre", 28'(clk6), 28'd0);
        @(negedge CK);
        chk("clk6_rise", 28'(clk6), 28'd1);
        chk("pix_en_drop", 28'(pix_en), 28'd0);
        chk("hcnt_first", 28'(hcnt), 28'd1);

        // Line wrap
        wait_hv(H_TOTAL - 1, 0, 1'b1);
        @(negedge CK);
        chk("line_wrap", {10'd0, hcnt, vcnt}, {10'd0, 9'd0, 9'd1});
        cnt_hs = 0;
        cnt_hb = 0;
        for (int i = 0; i < H_TOTAL * 4; i++) begin
            if (!hsync_n) cnt_hs++;
            if (!hblank_n) cnt_hb++;
            @(negedge CK);
        end
        chk("hsync_width", 28'(cnt_hs), 28'((HS_END - HS_START) * 4));
        chk("hblank_width", 28'(cnt_hb), 28'((H_TOTAL - H_ACTIVE) * 4));

        // Frame wrap
        wait_hv(H_TOTAL - 1, V_TOTAL - 1, 1'b1);
        @(negedge CK);
        chk("frame_wrap", {10'd0, hcnt, vcnt}, 28'd0);

        // Interrupt set and ack
        irq_en = 1'b1;
        wait_hv(H_TOTAL - 1, V_ACT_END - 1, 1'b1);
        @(negedge CK);
        chk("irq_set", {18'd0, vcnt, irq_n}, {18'd0, 9'(V_ACT_END), 1'b0});
        repeat (20) @(negedge CK);
        chk("irq_hold", 28'(irq_n), 28'd0);
        irq_ack = 1'b1;
        @(negedge CK);
        irq_ack = 1'b0;
        chk("irq_ack_clear", 28'(irq_n), 28'd1);

        // Disabled through vblank
        irq_en = 1'b0;
        wait_hv(H_TOTAL - 1, V_ACT_END - 1, 1'b1);
        repeat (9) @(negedge CK);
        chk("irq_disabled", 28'(irq_n), 28'd1);

        // Ack coincident with set
        irq_en = 1'b1;
        wait_hv(H_TOTAL - 1, V_ACT_END - 1, 1'b1);
        irq_ack = 1'b1;
        @(negedge CK);
        irq_ack = 1'b0;
        chk("coincide_vcnt", 28'(vcnt), 28'(V_ACT_END));
        chk("coincide_irq", 28'(irq_n), 28'd1);
        repeat (40) @(negedge CK);
        chk("coincide_hold", 28'(irq_n), 28'd1);

        // Asynchronous reset mid-frame
        wait_hv(20, V_ACT_START + 3, 1'b0);
        #3 Rn = 1'b0;
        #1 chk("async_reset", outs, RST_VEC);
        @(negedge CK);
        #2 Rn = 1'b1;
        @(negedge CK);
        chk("restart_e1", {10'd0, hcnt, vcnt}, 28'd0);
        @(negedge CK);
        chk("restart_e2", {10'd0, hcnt, vcnt}, {10'd0, 9'd1, 9'd0});
        repeat (4) @(negedge CK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
